// File: rtl/muxn_seq.sv
// muxn_seq: registered N-channel selector with valid/ready output and an
// auto-scan mode that dwells DWELL samples on each channel before stepping.

// One channel of the AND-OR mux: passes its data only when it is the
// selected channel, otherwise contributes zero.
module muxn_seq_lane #(
    parameter int W     = 4,
    parameter int K     = 0,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] eff_ch,
    input  logic [W-1:0]     d,
    output logic [W-1:0]     q
);
    assign q = (eff_ch == SEL_W'(K)) ? d : '0;
endmodule

module muxn_seq #(
    parameter int N_CH  = 8,
    parameter int W     = 4,
    parameter int DWELL = 2,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   din,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic                en,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sel_err
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_CH);

    typedef enum logic {DIRECT = 1'b0, SCAN = 1'b1} state_t;

    state_t                  mode_q, mode_nxt;
    logic                    entry, scan_act;
    logic                    load, in_range, last;
    logic [SEL_W-1:0]        ptr, eff_ch, wrap_ch;
    logic [SEL_W:0]          inc;
    logic [CW-1:0]           dwell_cnt, cnt_base;
    logic [N_CH-1:0][W-1:0]  lane_q;
    logic [W-1:0]            mux_q;

    // Mode tracker register: follows mode on every edge, stall or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= DIRECT;
        else        mode_q <= mode_nxt;
    end

    // Next mode state is simply the requested mode.
    always_comb begin
        mode_nxt = mode ? SCAN : DIRECT;
    end

    // Entry pulse when scan is requested while the tracker still says DIRECT;
    // steady scan uses the internal pointer.
    always_comb begin
        entry    = 1'b0;
        scan_act = 1'b0;
        if (mode) begin
            entry    = (mode_q == DIRECT);
            scan_act = (mode_q == SCAN);
        end
    end

    assign load     = !out_valid || out_ready;
    assign eff_ch   = scan_act ? ptr : sel;
    assign in_range = ({1'b0, eff_ch} < N_LIM);

    // Next channel modulo N_CH; eff_ch+1 never reaches 2*N_CH, so one
    // conditional subtract is enough even for an out-of-range entry select.
    assign inc     = {1'b0, eff_ch} + (SEL_W + 1)'(1);
    assign wrap_ch = (inc >= N_LIM) ? SEL_W'(inc - N_LIM) : inc[SEL_W-1:0];

    // On entry the dwell count restarts from zero for this very load.
    assign cnt_base = entry ? '0 : dwell_cnt;
    assign last     = (cnt_base == CW'(DWELL - 1));

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_lane
            muxn_seq_lane #(.W(W), .K(k), .SEL_W(SEL_W)) u_lane (
                .eff_ch (eff_ch),
                .d      (din[k*W +: W]),
                .q      (lane_q[k])
            );
        end
    endgenerate

    // OR-reduce the lanes; an out-of-range index matches no lane and yields 0.
    always_comb begin
        mux_q = '0;
        for (int i = 0; i < N_CH; i++) mux_q = mux_q | lane_q[i];
    end

    // Output register: loads when empty or accepted; en=0 leaves an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
        end else if (load) begin
            out_valid <= en;
            if (en) begin
                out_data <= mux_q;
                out_ch   <= eff_ch;
                if (!in_range) sel_err <= 1'b1;
            end
        end
    end

    // Scan pointer/dwell: advance on emitted scan samples; any entry that
    // does not emit a sample still restarts the scan from sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            dwell_cnt <= '0;
        end else if (load && en && mode) begin
            if (last) begin
                dwell_cnt <= '0;
                ptr       <= wrap_ch;
            end else begin
                dwell_cnt <= cnt_base + CW'(1);
                ptr       <= eff_ch;
            end
        end else if (entry) begin
            ptr       <= sel;
            dwell_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_muxn_seq.sv
// Randomized bench for muxn_seq: two instances (8 ch / dwell 2 and 5 ch /
// dwell 3) checked every cycle against a sample-sequence reference model,
// plus directed anchors with fixed expected values.
module tb_muxn_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din8 = '0;
    logic [19:0] din5 = '0;
    logic [2:0]  sel = '0;
    logic        mode = 1'b0, en = 1'b1, ready = 1'b1;
    logic [3:0]  d8, d5;
    logic [2:0]  c8, c5;
    logic        v8, v5, e8, e5;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    muxn_seq #(.N_CH(8), .W(4), .DWELL(2)) u8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .sel(sel), .mode(mode), .en(en),
        .out_data(d8), .out_ch(c8), .out_valid(v8), .out_ready(ready), .sel_err(e8));

    muxn_seq #(.N_CH(5), .W(4), .DWELL(3)) u5 (
        .clk(clk), .rst_n(rst_n), .din(din5), .sel(sel), .mode(mode), .en(en),
        .out_data(d5), .out_ch(c5), .out_valid(v5), .out_ready(ready), .sel_err(e5));

    // Reference model: per instance, the visible sample plus the scan
    // position as (channel, samples still owed on that channel).
    int nch[2] = '{8, 5};
    int dwl[2] = '{2, 3};
    int m_valid[2], m_data[2], m_ch[2], m_err[2], m_pm[2], m_ptr[2], m_left[2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int getd(input int i, input int ch);
        if (ch >= nch[i]) return 0;
        if (i == 0) return int'(din8[ch*4 +: 4]);
        return int'(din5[ch*4 +: 4]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_data[i] = 0; m_ch[i] = 0; m_err[i] = 0;
            m_pm[i] = 0; m_ptr[i] = 0; m_left[i] = dwl[i];
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int ch;
            bit ld;
            ld = (m_valid[i] == 0) || ready;
            if (mode && m_pm[i] == 0) begin
                m_ptr[i]  = int'(sel);
                m_left[i] = dwl[i];
            end
            ch = mode ? m_ptr[i] : int'(sel);
            if (ld) begin
                m_valid[i] = en;
                if (en) begin
                    m_data[i] = getd(i, ch);
                    m_ch[i]   = ch;
                    if (ch >= nch[i]) m_err[i] = 1;
                    if (mode) begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_ptr[i]  = (ch + 1) % nch[i];
                            m_left[i] = dwl[i];
                        end
                    end
                end
            end
            m_pm[i] = mode;
        end
    endtask

    task automatic check_all();
        chk("v8", v8, m_valid[0]); chk("d8", d8, m_data[0]);
        chk("c8", c8, m_ch[0]);    chk("e8", e8, m_err[0]);
        chk("v5", v5, m_valid[1]); chk("d5", d5, m_data[1]);
        chk("c5", c5, m_ch[1]);    chk("e5", e5, m_err[1]);
    endtask

    // One clock: predict, take the edge, sample 1 time unit later.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        int         exp_ch[3];
        pat = 8'b1000_1001;

        do_reset();
        chk("rst_v8", v8, 0);
        chk("rst_d8", d8, 0);

        // Direct sweep over the 1,0,0,1,0,0,0,1 pattern.
        for (int k = 0; k < 8; k++) din8[k*4 +: 4] = {3'b0, pat[k]};
        din5 = $urandom;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            step();
            chk("sw_d", d8, int'(pat[k]));
            chk("sw_c", c8, k);
            chk("sw_v", v8, 1);
        end

        // Scan from 6 with dwell 2, including a stall on the first ch-7 sample
        // and an enable gap.
        for (int k = 0; k < 8; k++) din8[k*4 +: 4] = 4'(k + 1);
        sel = 3'd6; mode = 1'b1;
        exp_ch = '{6, 6, 7};
        for (int j = 0; j < 3; j++) begin
            step(); chk("sc_c", c8, exp_ch[j]); chk("sc_d", d8, exp_ch[j] + 1);
        end
        ready = 1'b0; sel = 3'd2;
        for (int j = 0; j < 3; j++) begin
            step(); chk("bp_c", c8, 7); chk("bp_d", d8, 8); chk("bp_v", v8, 1);
        end
        ready = 1'b1;
        exp_ch = '{7, 0, 0};
        for (int j = 0; j < 3; j++) begin
            step(); chk("rs_c", c8, exp_ch[j]); chk("rs_d", d8, exp_ch[j] + 1);
        end
        en = 1'b0;
        for (int j = 0; j < 2; j++) begin
            step(); chk("gap_v", v8, 0);
        end
        en = 1'b1;
        exp_ch = '{1, 1, 2};
        for (int j = 0; j < 3; j++) begin
            step(); chk("en_c", c8, exp_ch[j]); chk("en_v", v8, 1);
        end

        // Out-of-range select on the 5-channel instance; sticky error.
        do_reset();
        mode = 1'b0; sel = 3'd6; en = 1'b1; din5 = 20'hABCDE;
        step();
        chk("oor_d", d5, 0); chk("oor_c", c5, 6); chk("oor_e", e5, 1);
        sel = 3'd2;
        step();
        chk("oor_stk", e5, 1); chk("oor_c2", c5, 2); chk("oor_d2", d5, 4'hC);
        step();
        chk("oor_stk2", e5, 1);
        do_reset();
        chk("oor_clr", e5, 0);

        // Reset in the middle of a scan stall; restart must use sel.
        mode = 1'b1; sel = 3'd1;
        step(); step();
        ready = 1'b0;
        step();
        chk("pre_v", v8, 1);
        #2;
        do_reset();
        chk("ar_v8", v8, 0); chk("ar_c8", c8, 0); chk("ar_d8", d8, 0);
        sel = 3'd3; ready = 1'b1;
        step();
        chk("ar_c8s", c8, 3); chk("ar_c5s", c5, 3);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            din8  = $urandom;
            din5  = 20'($urandom);
            sel   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            en    = ($urandom_range(0, 9) < 8);
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                do_reset();
            end else begin
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
